// File: rtl/regfile_hazard_scoreboard.sv
// RAW hazard scoreboard for the non-forwarding pipeline: tracks in-flight rd per stage and stalls ID.
// Optional macro REGFILE_WT_EN: regfile write-through, so the WB slot leaves the compare set.
module regfile_hazard_scoreboard #(
   parameter int STAGES = 3,
   parameter int CNT_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic [4:0]       i_rs1_addr,
   input  logic             i_rs1_used,
   input  logic [4:0]       i_rs2_addr,
   input  logic             i_rs2_used,
   input  logic [4:0]       i_rd_addr,
   input  logic             i_rd_wren,
   input  logic             i_hold,
   input  logic             i_flush,
   output logic             o_stall,
   output logic             o_issue,
   output logic [31:0]      o_busy_vec,
   output logic [CNT_W-1:0] o_stall_cnt
);

   // With write-through the WB slot can never cause a hazard, so it needs no storage.
`ifdef REGFILE_WT_EN
   localparam int NSLOT = STAGES - 1;
`else
   localparam int NSLOT = STAGES;
`endif

   logic             slot_v_reg  [NSLOT];
   logic [4:0]       slot_rd_reg [NSLOT];
   logic             slot_v_next [NSLOT];
   logic [4:0]       slot_rd_next[NSLOT];
   logic [31:0]      busy_cmp;
   logic             hazard1;
   logic             hazard2;
   logic [CNT_W-1:0] cnt_reg;

   always_comb begin
      busy_cmp = '0;
      for (int k = 0; k < NSLOT; k++) begin
         if (slot_v_reg[k]) begin
            busy_cmp[slot_rd_reg[k]] = 1'b1;
         end
      end
      busy_cmp[0] = 1'b0;
   end

   assign hazard1 = i_rs1_used && (i_rs1_addr != 5'd0) && busy_cmp[i_rs1_addr];
   assign hazard2 = i_rs2_used && (i_rs2_addr != 5'd0) && busy_cmp[i_rs2_addr];

   assign o_stall     = !i_rst && i_id_valid && !i_flush && (hazard1 || hazard2);
   assign o_issue     = !i_rst && i_id_valid && !i_flush && !o_stall && !i_hold;
   assign o_busy_vec  = i_rst ? 32'd0 : busy_cmp;
   assign o_stall_cnt = cnt_reg;

   // Slot 0 takes the issuing instruction (or a bubble); every later slot takes its predecessor.
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi == 0) begin : g_head
            assign slot_v_next[gi]  = o_issue && i_rd_wren && (i_rd_addr != 5'd0);
            assign slot_rd_next[gi] = o_issue ? i_rd_addr : 5'd0;
         end else begin : g_tail
            assign slot_v_next[gi]  = slot_v_reg[gi-1];
            assign slot_rd_next[gi] = slot_rd_reg[gi-1];
         end

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               slot_v_reg[gi]  <= 1'b0;
               slot_rd_reg[gi] <= 5'd0;
            end else if (!i_hold) begin
               slot_v_reg[gi]  <= slot_v_next[gi];
               slot_rd_reg[gi] <= slot_rd_next[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_reg <= '0;
      end else if (o_stall && !i_hold && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_hazard_scoreboard.sv
// Directed bench for regfile_hazard_scoreboard (STAGES=3, CNT_W=4) with a cycle model and expectation queue.
module tb_regfile_hazard_scoreboard;

   localparam int STAGES = 3;
   localparam int CNT_W  = 4;
`ifdef REGFILE_WT_EN
   localparam int N = STAGES - 1;
`else
   localparam int N = STAGES;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             id_valid = 1'b1;
   logic [4:0]       rs1_addr = 5'd5;
   logic             rs1_used = 1'b1;
   logic [4:0]       rs2_addr = 5'd0;
   logic             rs2_used = 1'b0;
   logic [4:0]       rd_addr = 5'd0;
   logic             rd_wren = 1'b0;
   logic             hold = 1'b0;
   logic             flush = 1'b0;
   logic             stall;
   logic             issue;
   logic [31:0]      busy_vec;
   logic [CNT_W-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   typedef struct {
      logic        stall;
      logic        issue;
      logic [31:0] busy;
      logic [3:0]  cnt;
   } exp_t;
   exp_t exp_q[$];

   logic       mv  [STAGES];
   logic [4:0] mrd [STAGES];
   int         m_cnt = 0;

   always #5 clk = ~clk;

   regfile_hazard_scoreboard #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
      .i_rs1_addr(rs1_addr), .i_rs1_used(rs1_used),
      .i_rs2_addr(rs2_addr), .i_rs2_used(rs2_used),
      .i_rd_addr(rd_addr), .i_rd_wren(rd_wren),
      .i_hold(hold), .i_flush(flush),
      .o_stall(stall), .o_issue(issue), .o_busy_vec(busy_vec), .o_stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: drive at negedge, queue the model's prediction, compare 1ns later.
   task automatic cyc(input logic v, input logic [4:0] a1, input logic u1,
                      input logic [4:0] a2, input logic u2, input logic [4:0] d,
                      input logic w, input logic h, input logic f, input logic r,
                      output logic st, output logic is);
      exp_t e;
      exp_t got;
      logic [31:0] bm;
      @(negedge clk);
      id_valid = v; rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2;
      rd_addr = d; rd_wren = w; hold = h; flush = f; rst = r;
      bm = '0;
      for (int k = 0; k < N; k++) if (mv[k]) bm[mrd[k]] = 1'b1;
      bm[0] = 1'b0;
      e.stall = !r && v && !f && ((u1 && a1 != 0 && bm[a1]) || (u2 && a2 != 0 && bm[a2]));
      e.issue = !r && v && !f && !e.stall && !h;
      e.busy  = r ? 32'd0 : bm;
      e.cnt   = 4'(m_cnt);
      exp_q.push_back(e);
      if (r) begin
         for (int k = 0; k < STAGES; k++) begin mv[k] = 1'b0; mrd[k] = 5'd0; end
         m_cnt = 0;
      end else if (!h) begin
         for (int k = STAGES - 1; k > 0; k--) begin mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; end
         mv[0]  = e.issue && w && (d != 0);
         mrd[0] = d;
         if (e.stall && m_cnt < 15) m_cnt++;
      end
      #1;
      got = exp_q.pop_front();
      step_no++;
      chk($sformatf("step%0d stall", step_no), 32'(stall), 32'(got.stall));
      chk($sformatf("step%0d issue", step_no), 32'(issue), 32'(got.issue));
      chk($sformatf("step%0d busy", step_no), busy_vec, got.busy);
      chk($sformatf("step%0d cnt", step_no), 32'(stall_cnt), 32'(got.cnt));
      $display("step %0d: v=%0b rs1=%0d rs2=%0d rd=%0d hold=%0b flush=%0b rst=%0b -> stall=%0b issue=%0b busy=%08h cnt=%0d",
               step_no, v, a1, a2, d, h, f, r, stall, issue, busy_vec, stall_cnt);
      st = stall;
      is = issue;
   endtask

   task automatic bubble(input int n);
      logic st, is;
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, is);
   endtask

   task automatic issue_rd(input logic [4:0] d);
      logic st, is;
      cyc(1, 0, 0, 0, 0, d, 1, 0, 0, 0, st, is);
      chk("producer_issue", 32'(is), 32'd1);
   endtask

   // Present a consumer of a1 until it issues (bounded); returns the stall cycles seen.
   task automatic consume(input logic [4:0] a1, output int stalls);
      logic st, is;
      bit done = 0;
      stalls = 0;
      for (int i = 0; i < 12 && !done; i++) begin
         cyc(1, a1, 1, 0, 0, 5'd20, 0, 0, 0, 0, st, is);
         if (st) stalls++;
         if (is) done = 1;
      end
      chk("consumer_issued", 32'(done), 32'd1);
   endtask

   initial begin
      logic st, is;
      int   stalls;
      for (int k = 0; k < STAGES; k++) begin mv[k] = 1'b0; mrd[k] = 5'd0; end

      // Reset held two cycles with a would-be hazard source.
      cyc(1, 5, 1, 0, 0, 5, 1, 0, 0, 1, st, is);
      cyc(1, 5, 1, 0, 0, 5, 1, 0, 0, 1, st, is);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_busy", busy_vec, 32'd0);
      chk("reset_cnt", 32'(stall_cnt), 32'd0);

      // First instruction after reset issues; it also produces x5.
      cyc(1, 5, 1, 0, 0, 5, 1, 0, 0, 0, st, is);
      chk("first_issue", 32'(is), 32'd1);

      // Back-to-back RAW on x5.
      cyc(1, 5, 1, 0, 0, 5'd20, 0, 0, 0, 0, st, is);
      chk("raw_busy", busy_vec, 32'h20);
      stalls = 0;
      consume(5, stalls);
      chk("raw_stall_len", 32'(stalls + 1), 32'(N));
      chk("raw_cnt", 32'(stall_cnt), 32'(N));
      bubble(4);

      // x0 destination and unused source never stall.
      issue_rd(0);
      cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, st, is);
      chk("x0_nostall", 32'(st), 32'd0);
      issue_rd(7);
      cyc(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, st, is);
      chk("unused_nostall", 32'(st), 32'd0);
      chk("unused_issue", 32'(is), 32'd1);
      bubble(4);

      // Hold for two cycles at stall cycle 1.
      issue_rd(9);
      cyc(1, 9, 1, 0, 0, 5'd20, 0, 0, 0, 0, st, is);
      chk("hold_first_stall", 32'(st), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc(1, 9, 1, 0, 0, 5'd20, 0, 1, 0, 0, st, is);
         chk("hold_stall", 32'(st), 32'd1);
         chk("hold_issue", 32'(is), 32'd0);
         chk("hold_cnt", 32'(stall_cnt), 32'(N + 1));
      end
      consume(9, stalls);
      chk("hold_total", 32'(stalls + 1), 32'(N));
      chk("hold_cnt_end", 32'(stall_cnt), 32'(2 * N));
      bubble(4);

      // Flush during a RAW stall on x3, then an independent instruction.
      issue_rd(3);
      cyc(1, 3, 1, 0, 0, 5'd20, 0, 0, 0, 0, st, is);
      chk("flush_pre_stall", 32'(st), 32'd1);
      cyc(1, 3, 1, 0, 0, 5'd20, 0, 0, 1, 0, st, is);
      chk("flush_stall", 32'(st), 32'd0);
      chk("flush_issue", 32'(is), 32'd0);
      cyc(1, 4, 1, 0, 0, 5'd20, 0, 0, 0, 0, st, is);
      chk("post_flush_issue", 32'(is), 32'd1);
      chk("flush_cnt", 32'(stall_cnt), 32'(2 * N + 1));
      bubble(4);

      // Saturation of the 4-bit counter.
      for (int r = 0; r < 8; r++) begin
         issue_rd(10);
         consume(10, stalls);
      end
      chk("sat_cnt", 32'(stall_cnt), 32'hF);
      bubble(4);

      // Reset in the middle of a stall.
      issue_rd(12);
      cyc(1, 12, 1, 0, 0, 5'd20, 0, 0, 0, 0, st, is);
      chk("midrst_pre_stall", 32'(st), 32'd1);
      cyc(1, 12, 1, 0, 0, 5'd20, 0, 0, 0, 1, st, is);
      chk("midrst_stall", 32'(st), 32'd0);
      cyc(1, 12, 1, 0, 0, 5'd20, 0, 0, 0, 0, st, is);
      chk("midrst_issue", 32'(is), 32'd1);
      chk("midrst_cnt", 32'(stall_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
